// File: rtl/spi_arbiter.sv
// -----------------------------------------------------------------------------
// spi_arbiter
// Two-requester SPI master front end. Requesters raise a level request; the
// arbiter picks a winner (round-robin on contention), captures that
// requester's 16-bit word and shifts it out MSB first in SPI mode 0 on the
// winner's chip select. Every output is driven straight from a register.
//
// Parameters:
//   DIV       clk cycles per SCLK half-period (1..255)
//
// Ports:
//   clk       system clock, rising edge
//   reset_L   asynchronous active-low reset
//   req       per-requester level request (bit n = requester n)
//   data0     requester 0 word, captured on grant decision
//   data1     requester 1 word, captured on grant decision
//   gnt       one-cycle grant pulse to the winner
//   done      one-cycle completion pulse to the served requester
//   busy      high while a transfer is in progress
//   spi_cs_L  per-slave active-low chip select
//   spi_sclk  SPI clock, idle low
//   spi_data  SPI MOSI, MSB first
//   bit_cnt   bits remaining in the current word, 16 when idle
// -----------------------------------------------------------------------------
module spi_arbiter #(
    parameter int unsigned DIV = 2
) (
    input  logic        clk,
    input  logic        reset_L,
    input  logic [1:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic        busy,
    output logic [1:0]  spi_cs_L,
    output logic        spi_sclk,
    output logic        spi_data,
    output logic [4:0]  bit_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SCLK_HI,
        ST_SCLK_LO
    } state_t;

    localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

    state_t      r_state,   w_state_nxt;
    logic [7:0]  r_div,     w_div_nxt;
    logic [15:0] r_shift,   w_shift_nxt;
    logic        r_last,    w_last_nxt;
    logic        r_sel,     w_sel_nxt;
    logic [1:0]  r_gnt,     w_gnt_nxt;
    logic [1:0]  r_done,    w_done_nxt;
    logic [1:0]  r_cs_L,    w_cs_L_nxt;
    logic        r_busy,    w_busy_nxt;
    logic        r_sclk,    w_sclk_nxt;
    logic [4:0]  r_bit_cnt, w_bit_cnt_nxt;

    logic        w_div_end;
    logic        w_win;
    logic [1:0]  w_win_oh;
    logic [1:0]  w_sel_oh;
    logic [15:0] w_word;

    assign w_div_end = (r_div == DIV_M1);
    // Contention goes to whoever was not served last; a lone requester wins outright.
    assign w_win     = (req == 2'b11) ? ~r_last : req[1];
    assign w_win_oh  = w_win ? 2'b10 : 2'b01;
    assign w_sel_oh  = r_sel ? 2'b10 : 2'b01;
    assign w_word    = w_win ? data1 : data0;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        w_state_nxt   = r_state;
        w_div_nxt     = r_div + 8'd1;
        w_shift_nxt   = r_shift;
        w_last_nxt    = r_last;
        w_sel_nxt     = r_sel;
        w_gnt_nxt     = 2'b00;
        w_done_nxt    = 2'b00;
        w_cs_L_nxt    = r_cs_L;
        w_busy_nxt    = r_busy;
        w_sclk_nxt    = r_sclk;
        w_bit_cnt_nxt = r_bit_cnt;

        case (r_state)
            ST_IDLE: begin
                w_div_nxt = 8'd0;
                if (req != 2'b00) begin
                    w_state_nxt = ST_SETUP;
                    w_shift_nxt = w_word;
                    w_last_nxt  = w_win;
                    w_sel_nxt   = w_win;
                    w_gnt_nxt   = w_win_oh;
                    w_cs_L_nxt  = ~w_win_oh;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_SETUP: begin
                if (w_div_end) begin
                    w_state_nxt = ST_SCLK_HI;
                    w_div_nxt   = 8'd0;
                    w_sclk_nxt  = 1'b1;
                end
            end
            ST_SCLK_HI: begin
                if (w_div_end) begin
                    // Falling SCLK: advance to the next bit; zeros fill in behind.
                    w_state_nxt   = ST_SCLK_LO;
                    w_div_nxt     = 8'd0;
                    w_sclk_nxt    = 1'b0;
                    w_shift_nxt   = {r_shift[14:0], 1'b0};
                    w_bit_cnt_nxt = r_bit_cnt - 5'd1;
                end
            end
            ST_SCLK_LO: begin
                if (w_div_end) begin
                    w_div_nxt = 8'd0;
                    if (r_bit_cnt == 5'd0) begin
                        w_state_nxt   = ST_IDLE;
                        w_cs_L_nxt    = 2'b11;
                        w_done_nxt    = w_sel_oh;
                        w_busy_nxt    = 1'b0;
                        w_bit_cnt_nxt = 5'd16;
                    end else begin
                        w_state_nxt = ST_SCLK_HI;
                        w_sclk_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            // NOTE: the shift register and pointer are reset along with the
            // control state so an aborted transfer leaves nothing behind.
            r_state   <= ST_IDLE;
            r_div     <= 8'd0;
            r_shift   <= 16'd0;
            r_last    <= 1'b1;
            r_sel     <= 1'b0;
            r_gnt     <= 2'b00;
            r_done    <= 2'b00;
            r_cs_L    <= 2'b11;
            r_busy    <= 1'b0;
            r_sclk    <= 1'b0;
            r_bit_cnt <= 5'd16;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above.
            r_state   <= w_state_nxt;
            r_div     <= w_div_nxt;
            r_shift   <= w_shift_nxt;
            r_last    <= w_last_nxt;
            r_sel     <= w_sel_nxt;
            r_gnt     <= w_gnt_nxt;
            r_done    <= w_done_nxt;
            r_cs_L    <= w_cs_L_nxt;
            r_busy    <= w_busy_nxt;
            r_sclk    <= w_sclk_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
        end
    end

    assign gnt      = r_gnt;
    assign done     = r_done;
    assign busy     = r_busy;
    assign spi_cs_L = r_cs_L;
    assign spi_sclk = r_sclk;
    // The MSB of the shift register is the bit on the wire; it drains to 0.
    assign spi_data = r_shift[15];
    assign bit_cnt  = r_bit_cnt;

endmodule

// File: tb/tb_spi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_arbiter
// Scoreboard bench for spi_arbiter. Instance a runs with DIV=2, instance b
// with DIV=1. Expected {requester, word} entries are queued when a request is
// driven; a negedge monitor rebuilds each word from MOSI at SCLK rising edges
// and compares it, plus timing, against the queue head on done.
// -----------------------------------------------------------------------------
module tb_spi_arbiter;

    logic clk;
    logic reset_L;

    logic [1:0]  req_a, req_b;
    logic [15:0] d0_a, d1_a, d0_b, d1_b;
    logic [1:0]  gnt_a, done_a, cs_a, gnt_b, done_b, cs_b;
    logic        busy_a, sclk_a, sd_a, busy_b, sclk_b, sd_b;
    logic [4:0]  bc_a, bc_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spi_arbiter #(.DIV(2)) u_dut_a (
        .clk(clk), .reset_L(reset_L), .req(req_a), .data0(d0_a), .data1(d1_a),
        .gnt(gnt_a), .done(done_a), .busy(busy_a), .spi_cs_L(cs_a),
        .spi_sclk(sclk_a), .spi_data(sd_a), .bit_cnt(bc_a)
    );

    spi_arbiter #(.DIV(1)) u_dut_b (
        .clk(clk), .reset_L(reset_L), .req(req_b), .data0(d0_b), .data1(d1_b),
        .gnt(gnt_b), .done(done_b), .busy(busy_b), .spi_cs_L(cs_b),
        .spi_sclk(sclk_b), .spi_data(sd_b), .bit_cnt(bc_b)
    );

    typedef struct {
        int          k;
        int          id;
        logic [15:0] word;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // monitor state, indexed by instance (0 = a, 1 = b)
    int          m_len[2]   = '{0, 0};
    int          m_edges[2] = '{0, 0};
    int          m_hi[2]    = '{0, 0};
    int          m_gap[2]   = '{0, 0};
    int          m_dones[2] = '{0, 0};
    logic [15:0] m_word[2]  = '{16'd0, 16'd0};
    logic        m_psclk[2] = '{1'b0, 1'b0};
    bit          chk_gap[2] = '{1'b0, 1'b0};
    int          viol = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int k, input int id, input logic [15:0] word);
        exp_t e;
        e.k = k; e.id = id; e.word = word;
        sb.push_back(e);
    endtask

    task automatic mon(input int k, input logic [1:0] cs, input logic sclk, input logic sd,
                       input logic [1:0] g, input logic [1:0] d, input int div);
        exp_t e;
        if (cs == 2'b00) viol++;
        if (|g && |d) viol++;
        if (|g) begin
            if (sb.size() == 0) check("unexpected_gnt", {30'd0, g}, 32'd0);
            else check($sformatf("gnt_id_%0d", k), {30'd0, g}, 32'd1 << sb[0].id);
            if (chk_gap[k] && m_dones[k] > 0) check("cs_gap", m_gap[k], 1);
            m_len[k] = 0; m_edges[k] = 0; m_hi[k] = 0; m_word[k] = 16'd0;
        end
        if (cs != 2'b11) begin
            m_len[k]++;
            if (sclk) m_hi[k]++;
            if (sclk && !m_psclk[k]) begin
                m_word[k] = {m_word[k][14:0], sd};
                m_edges[k]++;
            end
            m_gap[k] = 0;
        end else begin
            m_gap[k]++;
        end
        if (|d) begin
            m_dones[k]++;
            if (sb.size() == 0) begin
                check("unexpected_done", {30'd0, d}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_instance", k, e.k);
                check($sformatf("done_id_%0d", k), {30'd0, d}, 32'd1 << e.id);
                check($sformatf("mosi_word_%0d", k), m_word[k], e.word);
                check("sclk_edges", m_edges[k], 16);
                check("cs_low_cycles", m_len[k], 33 * div);
                check("sclk_hi_cycles", m_hi[k], 16 * div);
            end
        end
        m_psclk[k] = sclk;
    endtask

    always @(negedge clk) begin
        if (reset_L) begin
            mon(0, cs_a, sclk_a, sd_a, gnt_a, done_a, 2);
            mon(1, cs_b, sclk_b, sd_b, gnt_b, done_b, 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int k, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if ((k == 0 ? done_a : done_b) != 2'b00) begin
                n = i;
                return;
            end
        end
        check("timeout_done", 0, 1);
    endtask

    task automatic wait_bitcnt(input logic [4:0] val, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bc_a == val) return;
        end
        check("timeout_bitcnt", 0, 1);
    endtask

    int n;

    initial begin
        req_a = 2'b00; req_b = 2'b00;
        d0_a = 16'd0; d1_a = 16'd0; d0_b = 16'd0; d1_b = 16'd0;
        reset_L = 1'b1;
        #1 reset_L = 1'b0;
        #1;
        check("rst_cs", {30'd0, cs_a}, 32'h3);
        check("rst_sclk", {31'd0, sclk_a}, 32'd0);
        check("rst_data", {31'd0, sd_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_gnt_done", {28'd0, gnt_a, done_a}, 32'd0);
        check("rst_bitcnt", {27'd0, bc_a}, 32'd16);
        repeat (3) @(posedge clk);
        #1 reset_L = 1'b1;
        tick(); tick();
        check("idle_bitcnt", {27'd0, bc_a}, 32'd16);

        // Both requesting continuously: 0,1,0,1 with one-cycle cs-high gaps.
        chk_gap[0] = 1'b1;
        d0_a = 16'h1234; d1_a = 16'hBEEF;
        push(0, 0, 16'h1234); push(0, 1, 16'hBEEF);
        push(0, 0, 16'h1234); push(0, 1, 16'hBEEF);
        req_a = 2'b11;
        for (int i = 0; i < 4; i++) wait_done(0, 200, n);
        req_a = 2'b00;
        chk_gap[0] = 1'b0;
        repeat (3) tick();

        // Single requester 0, DIV=2: grant latency, cs shape, done latency.
        d0_a = 16'hA5C3;
        push(0, 0, 16'hA5C3);
        req_a = 2'b01;
        tick();
        check("gnt_at_T1", {30'd0, gnt_a}, 32'h1);
        check("cs_at_T1", {30'd0, cs_a}, 32'h2);
        check("busy_at_T1", {31'd0, busy_a}, 32'd1);
        check("msb_at_T1", {31'd0, sd_a}, 32'd1);
        tick();
        check("gnt_one_cycle", {30'd0, gnt_a}, 32'd0);
        req_a = 2'b00;
        wait_done(0, 200, n);
        check("done_latency_div2", n, 65);
        tick();
        check("done_one_cycle", {30'd0, done_a}, 32'd0);
        check("idle_cs", {30'd0, cs_a}, 32'h3);
        check("idle_busy", {31'd0, busy_a}, 32'd0);
        check("idle_bitcnt2", {27'd0, bc_a}, 32'd16);
        repeat (2) tick();

        // Request dropped after grant, data0 changed, requester 1 raised mid-word.
        d0_a = 16'h3C5A;
        push(0, 0, 16'h3C5A); push(0, 1, 16'h0F0F);
        req_a = 2'b01;
        tick();
        req_a = 2'b00; d0_a = 16'hFFFF; d1_a = 16'h0F0F;
        repeat (10) tick();
        req_a = 2'b10;
        wait_done(0, 200, n);
        check("done0_first", {30'd0, done_a}, 32'h1);
        tick();
        check("gnt1_after_done0", {30'd0, gnt_a}, 32'h2);
        req_a = 2'b00;
        wait_done(0, 200, n);
        repeat (2) tick();

        // Reset in the middle of a word.
        d0_a = 16'h5555;
        push(0, 0, 16'h5555);
        req_a = 2'b01;
        tick();
        req_a = 2'b00;
        wait_bitcnt(5'd7, 300);
        reset_L = 1'b0;
        #1;
        sb.delete();
        check("abort_cs", {30'd0, cs_a}, 32'h3);
        check("abort_sclk", {31'd0, sclk_a}, 32'd0);
        check("abort_bitcnt", {27'd0, bc_a}, 32'd16);
        check("abort_done", {30'd0, done_a}, 32'd0);
        check("abort_busy", {31'd0, busy_a}, 32'd0);
        d1_a = 16'h9A3C;
        req_a = 2'b10;
        push(0, 1, 16'h9A3C);
        tick(); tick();
        reset_L = 1'b1;
        tick();
        check("gnt_after_reset", {30'd0, gnt_a}, 32'h2);
        req_a = 2'b00;
        wait_done(0, 200, n);
        repeat (2) tick();

        // DIV=1, requester 1: all-ones then all-zeros back to back.
        d1_b = 16'hFFFF;
        push(1, 1, 16'hFFFF); push(1, 1, 16'h0000);
        req_b = 2'b10;
        tick();
        check("gnt_b_T1", {30'd0, gnt_b}, 32'h2);
        d1_b = 16'h0000;
        wait_done(1, 100, n);
        check("done_latency_div1", n, 33);
        tick();
        check("gnt_b_regrant", {30'd0, gnt_b}, 32'h2);
        req_b = 2'b00;
        wait_done(1, 100, n);
        repeat (3) tick();

        check("cs_gnt_exclusive_viol", viol, 0);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
